// File: rtl/phy_tx_pkg.sv
// Shared constants and state encoding for the phy_tx byte scheduler.
package phy_tx_pkg;

  // Comma (training / skip) and idle control symbols.
  localparam logic [7:0] COM_BYTE = 8'hBC;
  localparam logic [7:0] IDL_BYTE = 8'h7C;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// ascending with wrap. The caller owns and advances the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic                 any_grant
);

  logic [NUM_LANES-1:0] req_rot;
  logic [NUM_LANES-1:0] gnt_rot;
  logic                 found;

  // Rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_rot = NUM_LANES'({req, req} >> ptr);
    gnt_rot = '0;
    found   = 1'b0;
    for (int o = 0; o < NUM_LANES; o++) begin
      if (!found && req_rot[o]) begin
        gnt_rot[o] = 1'b1;
        found      = 1'b1;
      end
    end
    grant     = NUM_LANES'(({gnt_rot, gnt_rot} << ptr) >> NUM_LANES);
    any_grant = found;
  end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Byte-slot scheduler in front of the phy_tx serializer. Sends a COM training
// burst after reset, then round-robins lane bytes, filling gaps with IDL.
// Optional periodic COM insertion is enabled by defining PHY_TX_SKIP_INSERT_EN.
module phy_tx_lane_scheduler
  import phy_tx_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned COM_COUNT     = 4,
  parameter int unsigned SKIP_INTERVAL = 16
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [8*NUM_LANES-1:0] lane_data,
  output logic [NUM_LANES-1:0]   lane_ready,
  input  logic                   ser_ready,
  output logic [7:0]             out_data,
  output logic                   out_k,
  output logic                   out_valid,
  output logic                   sync_done
);

  localparam int unsigned PtrW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_e   state_q, state_d;
  logic [7:0]     com_cnt_q, com_cnt_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_k_q, out_k_d;
  logic           out_valid_q;

  logic [NUM_LANES-1:0] grant;
  logic                 any_grant;
  logic [PtrW-1:0]      grant_idx;
  logic [7:0]           grant_byte;
  logic                 xfer;
  logic                 train_last;
  logic                 arb_sel;
  logic                 force_com;

`ifdef PHY_TX_SKIP_INSERT_EN
  logic [7:0] skip_cnt_q, skip_cnt_d;
  assign force_com = (state_q == ACTIVE) && (skip_cnt_q == 8'(SKIP_INTERVAL - 1));
`else
  logic unused_skip_interval;
  assign unused_skip_interval = ^SKIP_INTERVAL;
  assign force_com = 1'b0;
`endif

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .PTR_W     (PtrW)
  ) u_rr_arbiter (
    .req       (lane_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign xfer       = out_valid_q & ser_ready;
  assign train_last = (com_cnt_q == 8'(COM_COUNT - 1));
  // The last training transfer already loads an arbitrated byte.
  assign arb_sel    = (state_q == ACTIVE) || train_last;

  // One-hot grant to lane index and its byte.
  always_comb begin
    grant_idx  = '0;
    grant_byte = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) begin
        grant_idx  = i[PtrW-1:0];
        grant_byte = grant_byte | lane_data[i*8 +: 8];
      end
    end
  end

  // Next-state: everything holds unless the serializer takes the current byte.
  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    out_data_d = out_data_q;
    out_k_d    = out_k_q;
    lane_ready = '0;
`ifdef PHY_TX_SKIP_INSERT_EN
    skip_cnt_d = skip_cnt_q;
    if (xfer && (state_q == ACTIVE)) begin
      skip_cnt_d = force_com ? 8'd0 : skip_cnt_q + 8'd1;
    end
`endif
    if (xfer) begin
      if (state_q == TRAIN) begin
        com_cnt_d = com_cnt_q + 8'd1;
        if (train_last) state_d = ACTIVE;
      end
      if (!arb_sel || force_com) begin
        out_data_d = COM_BYTE;
        out_k_d    = 1'b1;
      end else if (any_grant) begin
        out_data_d = grant_byte;
        out_k_d    = 1'b0;
        lane_ready = grant;
        rr_ptr_d   = (grant_idx == PtrW'(NUM_LANES - 1)) ? '0 : grant_idx + PtrW'(1);
      end else begin
        out_data_d = IDL_BYTE;
        out_k_d    = 1'b1;
      end
    end
  end

  // State and output registers; reset discards any held byte.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= TRAIN;
      com_cnt_q   <= 8'd0;
      rr_ptr_q    <= '0;
      out_data_q  <= COM_BYTE;
      out_k_q     <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef PHY_TX_SKIP_INSERT_EN
      skip_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      com_cnt_q   <= com_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      out_valid_q <= 1'b1;
`ifdef PHY_TX_SKIP_INSERT_EN
      skip_cnt_q  <= skip_cnt_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_k     = out_k_q;
  assign out_valid = out_valid_q;
  assign sync_done = (state_q == ACTIVE);

endmodule
